// File: rtl/cache_mem_arbiter.sv
// Shares one cache-line memory port between the icache and dcache.
//
// Read side: a three-state FSM grants one refill at a time. The dcache wins
// ties unless the icache has watched STARVE_LIMIT consecutive dcache grants go
// by, in which case the icache is forced through. Return beats are steered to
// the owner of the outstanding read; data and last are broadcast.
// Write side: a single-entry victim buffer for dcache write-backs. While it
// holds a line, reads of that line are held off until memory reports the
// write complete.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   i_rd_req/type/addr, i_rd_rdy    icache read request and accept pulse
//   d_rd_req/type/addr, d_rd_rdy    dcache read request and accept pulse
//   i_ret_valid, d_ret_valid        per-cache return beat valid
//   ret_last, ret_data              return beat last/data, broadcast
//   d_wr_req/addr/data, d_wr_rdy    dcache line write-back, accepted when buffer empty
//   m_rd_req/type/addr, m_rd_rdy    memory read request channel
//   m_ret_valid/last/data           memory return beats
//   m_wr_req/addr/data, m_wr_rdy    memory write request channel (full line)
//   m_wr_done                       memory write response
module cache_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_rd_req,
    input  logic [2:0]   i_rd_type,
    input  logic [31:0]  i_rd_addr,
    output logic         i_rd_rdy,
    output logic         i_ret_valid,
    input  logic         d_rd_req,
    input  logic [2:0]   d_rd_type,
    input  logic [31:0]  d_rd_addr,
    output logic         d_rd_rdy,
    output logic         d_ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         d_wr_req,
    input  logic [31:0]  d_wr_addr,
    input  logic [127:0] d_wr_data,
    output logic         d_wr_rdy,
    output logic         m_rd_req,
    output logic [2:0]   m_rd_type,
    output logic [31:0]  m_rd_addr,
    input  logic         m_rd_rdy,
    input  logic         m_ret_valid,
    input  logic         m_ret_last,
    input  logic [31:0]  m_ret_data,
    output logic         m_wr_req,
    output logic [31:0]  m_wr_addr,
    output logic [127:0] m_wr_data,
    input  logic         m_wr_rdy,
    input  logic         m_wr_done
);

    localparam int unsigned AW       = 32;
    localparam int unsigned TW       = 3;
    localparam int unsigned LW       = 128;
    localparam int unsigned LINE_LSB = 4;
    localparam int unsigned CW       = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_RET} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} wr_state_e;

    rd_state_e       r_state_q, r_state_d;
    logic            rd_own_i_q, rd_own_i_d;
    logic [TW-1:0]   rd_type_q, rd_type_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [CW-1:0]   starve_q, starve_d;

    wr_state_e       w_state_q, w_state_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [LW-1:0]   wr_data_q, wr_data_d;

    logic            wr_busy;
    logic            i_elig;
    logic            d_elig;
    logic            starved;
    logic            grant_i;
    logic            grant_d;

    // A buffered victim line blocks reads of the same line until write done.
    assign wr_busy = (w_state_q != W_IDLE);
    assign i_elig  = i_rd_req && !(wr_busy && (i_rd_addr[AW-1:LINE_LSB] == wr_addr_q[AW-1:LINE_LSB]));
    assign d_elig  = d_rd_req && !(wr_busy && (d_rd_addr[AW-1:LINE_LSB] == wr_addr_q[AW-1:LINE_LSB]));

    // Dcache has priority unless the icache has been passed over too often.
    assign starved = (starve_q == CW'(STARVE_LIMIT));
    assign grant_i = i_elig && (starved || !d_elig);
    assign grant_d = d_elig && !grant_i;

    // Latched request and buffered write are visible on the memory port.
    assign m_rd_type = reset ? '0 : rd_type_q;
    assign m_rd_addr = reset ? '0 : rd_addr_q;
    assign m_wr_addr = reset ? '0 : wr_addr_q;
    assign m_wr_data = reset ? '0 : wr_data_q;

    // State registers for both channels.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= R_IDLE;
            rd_own_i_q <= 1'b0;
            rd_type_q  <= '0;
            rd_addr_q  <= '0;
            starve_q   <= '0;
            w_state_q  <= W_IDLE;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            r_state_q  <= r_state_d;
            rd_own_i_q <= rd_own_i_d;
            rd_type_q  <= rd_type_d;
            rd_addr_q  <= rd_addr_d;
            starve_q   <= starve_d;
            w_state_q  <= w_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Read FSM: grant, issue to memory, forward beats to the owner.
    always_comb begin
        r_state_d   = r_state_q;
        rd_own_i_d  = rd_own_i_q;
        rd_type_d   = rd_type_q;
        rd_addr_d   = rd_addr_q;
        starve_d    = starve_q;
        i_rd_rdy    = 1'b0;
        d_rd_rdy    = 1'b0;
        m_rd_req    = 1'b0;
        i_ret_valid = 1'b0;
        d_ret_valid = 1'b0;
        ret_last    = 1'b0;
        ret_data    = '0;
        if (!reset) begin
            case (r_state_q)
                R_IDLE: begin
                    if (grant_i) begin
                        i_rd_rdy   = 1'b1;
                        rd_own_i_d = 1'b1;
                        rd_type_d  = i_rd_type;
                        rd_addr_d  = i_rd_addr;
                        starve_d   = '0;
                        r_state_d  = R_REQ;
                    end else if (grant_d) begin
                        d_rd_rdy   = 1'b1;
                        rd_own_i_d = 1'b0;
                        rd_type_d  = d_rd_type;
                        rd_addr_d  = d_rd_addr;
                        // Only grants made while the icache waits count as starvation.
                        if (i_rd_req && !starved) begin
                            starve_d = starve_q + CW'(1);
                        end
                        r_state_d  = R_REQ;
                    end
                end
                R_REQ: begin
                    m_rd_req = 1'b1;
                    if (m_rd_rdy) begin
                        r_state_d = R_RET;
                    end
                end
                R_RET: begin
                    i_ret_valid = rd_own_i_q && m_ret_valid;
                    d_ret_valid = !rd_own_i_q && m_ret_valid;
                    ret_last    = m_ret_last;
                    ret_data    = m_ret_data;
                    if (m_ret_valid && m_ret_last) begin
                        r_state_d = R_IDLE;
                    end
                end
                default: r_state_d = R_IDLE;
            endcase
        end
    end

    // Write FSM: capture a victim line, issue it, wait for the response.
    always_comb begin
        w_state_d = w_state_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        d_wr_rdy  = 1'b0;
        m_wr_req  = 1'b0;
        if (!reset) begin
            case (w_state_q)
                W_IDLE: begin
                    d_wr_rdy = 1'b1;
                    if (d_wr_req) begin
                        wr_addr_d = d_wr_addr;
                        wr_data_d = d_wr_data;
                        w_state_d = W_REQ;
                    end
                end
                W_REQ: begin
                    m_wr_req = 1'b1;
                    if (m_wr_rdy) begin
                        w_state_d = W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (m_wr_done) begin
                        w_state_d = W_IDLE;
                    end
                end
                default: w_state_d = W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_cache_mem_arbiter;

    localparam int STARVE = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_rd_req;
    logic [2:0]   i_rd_type;
    logic [31:0]  i_rd_addr;
    logic         i_rd_rdy;
    logic         i_ret_valid;
    logic         d_rd_req;
    logic [2:0]   d_rd_type;
    logic [31:0]  d_rd_addr;
    logic         d_rd_rdy;
    logic         d_ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         d_wr_req;
    logic [31:0]  d_wr_addr;
    logic [127:0] d_wr_data;
    logic         d_wr_rdy;
    logic         m_rd_req;
    logic [2:0]   m_rd_type;
    logic [31:0]  m_rd_addr;
    logic         m_rd_rdy;
    logic         m_ret_valid;
    logic         m_ret_last;
    logic [31:0]  m_ret_data;
    logic         m_wr_req;
    logic [31:0]  m_wr_addr;
    logic [127:0] m_wr_data;
    logic         m_wr_rdy;
    logic         m_wr_done;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .reset(reset),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid),
        .ret_last(ret_last), .ret_data(ret_data),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
        .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last), .m_ret_data(m_ret_data),
        .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
        .m_wr_rdy(m_wr_rdy), .m_wr_done(m_wr_done)
    );

    // Reference model: an outstanding read record and a pending write record.
    typedef struct packed {
        logic        own_i;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic        issued;
    } rd_txn_t;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         acked;
    } wr_ent_t;

    rd_txn_t      rd_q[$];
    wr_ent_t      wr_q[$];
    int           streak;
    logic [2:0]   last_type;
    logic [31:0]  last_raddr;
    logic [31:0]  last_waddr;
    logic [127:0] last_wdata;
    logic         win_i;
    logic         win_d;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line_blocked(input logic [31:0] a);
        if (wr_q.size() == 0) return 1'b0;
        return (a >> 4) == (wr_q[0].addr >> 4);
    endfunction

    // Settle inputs, then compare every output with the model's prediction.
    task automatic eval();
        logic         ie;
        logic         de;
        logic         e_mreq;
        logic         e_iret;
        logic         e_dret;
        logic         e_last;
        logic [31:0]  e_data;
        logic         e_wrdy;
        logic         e_mwreq;
        logic [2:0]   e_mtype;
        logic [31:0]  e_maddr;
        logic [31:0]  e_mwaddr;
        logic [127:0] e_mwdata;
        #1;
        win_i = 1'b0; win_d = 1'b0;
        e_mreq = 1'b0; e_iret = 1'b0; e_dret = 1'b0; e_last = 1'b0; e_data = '0;
        e_wrdy = 1'b0; e_mwreq = 1'b0; e_mtype = '0; e_maddr = '0; e_mwaddr = '0; e_mwdata = '0;
        if (!reset) begin
            if (rd_q.size() == 0) begin
                ie = i_rd_req && !line_blocked(i_rd_addr);
                de = d_rd_req && !line_blocked(d_rd_addr);
                if (ie && (streak >= STARVE || !de)) win_i = 1'b1;
                else if (de) win_d = 1'b1;
            end else if (!rd_q[0].issued) begin
                e_mreq = 1'b1;
            end else begin
                e_iret = rd_q[0].own_i && m_ret_valid;
                e_dret = !rd_q[0].own_i && m_ret_valid;
                e_last = m_ret_last;
                e_data = m_ret_data;
            end
            e_mtype = last_type;
            e_maddr = last_raddr;
            if (wr_q.size() == 0) e_wrdy = 1'b1;
            else if (!wr_q[0].acked) e_mwreq = 1'b1;
            e_mwaddr = last_waddr;
            e_mwdata = last_wdata;
        end
        chk("i_rd_rdy",    128'(i_rd_rdy),    128'(win_i));
        chk("d_rd_rdy",    128'(d_rd_rdy),    128'(win_d));
        chk("m_rd_req",    128'(m_rd_req),    128'(e_mreq));
        chk("m_rd_type",   128'(m_rd_type),   128'(e_mtype));
        chk("m_rd_addr",   128'(m_rd_addr),   128'(e_maddr));
        chk("i_ret_valid", 128'(i_ret_valid), 128'(e_iret));
        chk("d_ret_valid", 128'(d_ret_valid), 128'(e_dret));
        chk("ret_last",    128'(ret_last),    128'(e_last));
        chk("ret_data",    128'(ret_data),    128'(e_data));
        chk("d_wr_rdy",    128'(d_wr_rdy),    128'(e_wrdy));
        chk("m_wr_req",    128'(m_wr_req),    128'(e_mwreq));
        chk("m_wr_addr",   128'(m_wr_addr),   128'(e_mwaddr));
        chk("m_wr_data",   m_wr_data,         e_mwdata);
    endtask

    // Advance the model by one cycle using this cycle's inputs, then clock.
    task automatic adv();
        rd_txn_t t;
        wr_ent_t w;
        if (reset) begin
            rd_q.delete(); wr_q.delete();
            streak = 0; last_type = '0; last_raddr = '0; last_waddr = '0; last_wdata = '0;
        end else begin
            if (win_i || win_d) begin
                t.own_i  = win_i;
                t.typ    = win_i ? i_rd_type : d_rd_type;
                t.addr   = win_i ? i_rd_addr : d_rd_addr;
                t.issued = 1'b0;
                rd_q.push_back(t);
                last_type  = t.typ;
                last_raddr = t.addr;
                if (win_i) streak = 0;
                else if (i_rd_req && streak < STARVE) streak++;
            end else if (rd_q.size() != 0) begin
                if (!rd_q[0].issued) begin
                    if (m_rd_rdy) begin
                        t = rd_q[0]; t.issued = 1'b1; rd_q[0] = t;
                    end
                end else if (m_ret_valid && m_ret_last) begin
                    void'(rd_q.pop_front());
                end
            end
            if (wr_q.size() == 0) begin
                if (d_wr_req) begin
                    w.addr = d_wr_addr; w.data = d_wr_data; w.acked = 1'b0;
                    wr_q.push_back(w);
                    last_waddr = d_wr_addr; last_wdata = d_wr_data;
                end
            end else if (!wr_q[0].acked) begin
                if (m_wr_rdy) begin
                    w = wr_q[0]; w.acked = 1'b1; wr_q[0] = w;
                end
            end else if (m_wr_done) begin
                void'(wr_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    initial begin
        int dg;
        int ig;
        int dblk;
        logic got_i;
        reset = 1'b1;
        i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
        d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
        d_wr_req = 0; d_wr_addr = 0; d_wr_data = 0;
        m_rd_rdy = 0; m_ret_valid = 0; m_ret_last = 0; m_ret_data = 0;
        m_wr_rdy = 0; m_wr_done = 0;
        streak = 0; last_type = 0; last_raddr = 0; last_waddr = 0; last_wdata = 0;
        @(posedge clk); #1;
        step(); step();
        reset = 1'b0;

        // Same-cycle requests: dcache first, icache in the idle cycle after its last beat.
        i_rd_req = 1; i_rd_type = 3'd4; i_rd_addr = 32'h1c00_0000;
        d_rd_req = 1; d_rd_type = 3'd4; d_rd_addr = 32'h0000_1000;
        eval();
        chk("prio_d_first", 128'(d_rd_rdy), 128'(1));
        chk("prio_i_wait",  128'(i_rd_rdy), 128'(0));
        adv();
        d_rd_req = 0; m_rd_rdy = 1;
        eval();
        chk("prio_m_addr", 128'(m_rd_addr), 128'(32'h0000_1000));
        adv();
        m_rd_rdy = 0;
        for (int k = 1; k <= 4; k++) begin
            m_ret_valid = 1; m_ret_last = (k == 4); m_ret_data = 32'hA000_0000 + 32'(k);
            eval();
            chk("prio_d_beat", 128'(d_ret_valid), 128'(1));
            chk("prio_i_none", 128'(i_ret_valid), 128'(0));
            adv();
        end
        m_ret_valid = 0; m_ret_last = 0;
        eval();
        chk("prio_i_after_last", 128'(i_rd_rdy), 128'(1));
        adv();
        i_rd_req = 0; m_rd_rdy = 1;
        step();
        m_rd_rdy = 0;

        // Routing of a four-beat icache refill.
        for (int k = 1; k <= 4; k++) begin
            m_ret_valid = 1; m_ret_last = (k == 4); m_ret_data = 32'(k) * 32'h1111_1111;
            eval();
            chk("route_i_valid", 128'(i_ret_valid), 128'(1));
            chk("route_d_valid", 128'(d_ret_valid), 128'(0));
            chk("route_last",    128'(ret_last),    128'(k == 4));
            chk("route_data",    128'(ret_data),    128'(32'(k) * 32'h1111_1111));
            adv();
        end
        m_ret_valid = 0; m_ret_last = 0;
        step();

        // Starvation: four dcache grants, then the icache, twice over.
        i_rd_req = 1; i_rd_type = 3'd4; i_rd_addr = 32'h0000_3000;
        d_rd_req = 1; d_rd_type = 3'd2;
        m_rd_rdy = 1; m_ret_valid = 1; m_ret_last = 1; m_ret_data = 32'h5a5a_0000;
        for (int rep = 0; rep < 2; rep++) begin
            dg = 0; got_i = 0;
            for (int c = 0; c < 60 && !got_i; c++) begin
                d_rd_addr = 32'h0000_4000 + 32'(c) * 32'd16;
                eval();
                if (i_rd_rdy) got_i = 1;
                else if (d_rd_rdy) dg++;
                adv();
            end
            chk("starve_d_grants", 128'(dg), 128'(STARVE));
            chk("starve_i_grant",  128'(got_i), 128'(1));
        end
        i_rd_req = 0; d_rd_req = 0;
        for (int c = 0; c < 4; c++) step();
        m_rd_rdy = 0; m_ret_valid = 0; m_ret_last = 0;

        // Hazard: read of a buffered line waits for the write response.
        d_wr_req = 1; d_wr_addr = 32'h0000_2000;
        d_wr_data = {32'hdddd_0003, 32'hcccc_0002, 32'hbbbb_0001, 32'haaaa_0000};
        eval();
        chk("wb_accept", 128'(d_wr_rdy), 128'(1));
        adv();
        d_wr_req = 0; m_wr_rdy = 1;
        eval();
        chk("wb_m_req",  128'(m_wr_req),  128'(1));
        chk("wb_m_addr", 128'(m_wr_addr), 128'(32'h0000_2000));
        chk("wb_m_data", m_wr_data, {32'hdddd_0003, 32'hcccc_0002, 32'hbbbb_0001, 32'haaaa_0000});
        adv();
        m_wr_rdy = 0;
        d_rd_req = 1; d_rd_type = 3'd4; d_rd_addr = 32'h0000_2008;
        i_rd_req = 1; i_rd_type = 3'd4; i_rd_addr = 32'h0000_3000;
        m_rd_rdy = 1; m_ret_valid = 1; m_ret_last = 1;
        ig = 0; dblk = 0;
        for (int c = 0; c < 10; c++) begin
            eval();
            if (i_rd_rdy) ig++;
            if (d_rd_rdy) dblk++;
            adv();
            if (win_i) i_rd_req = 0;
        end
        chk("haz_i_granted", 128'(ig),   128'(1));
        chk("haz_d_blocked", 128'(dblk), 128'(0));
        m_wr_done = 1;
        eval();
        chk("haz_done_cycle", 128'(d_rd_rdy), 128'(0));
        adv();
        m_wr_done = 0;
        eval();
        chk("haz_after_done", 128'(d_rd_rdy), 128'(1));
        adv();
        d_rd_req = 0;
        for (int c = 0; c < 4; c++) step();
        m_rd_rdy = 0; m_ret_valid = 0; m_ret_last = 0;

        // Uncached single-word dcache read.
        d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'hbfaf_8000;
        eval();
        chk("unc_grant", 128'(d_rd_rdy), 128'(1));
        adv();
        d_rd_req = 0; m_rd_rdy = 1;
        eval();
        chk("unc_m_req",  128'(m_rd_req),  128'(1));
        chk("unc_m_type", 128'(m_rd_type), 128'(3'd2));
        chk("unc_m_addr", 128'(m_rd_addr), 128'(32'hbfaf_8000));
        adv();
        m_rd_rdy = 0; m_ret_valid = 1; m_ret_last = 1; m_ret_data = 32'hcafe_f00d;
        eval();
        chk("unc_beat", 128'(d_ret_valid), 128'(1));
        chk("unc_last", 128'(ret_last),    128'(1));
        adv();
        eval();
        chk("unc_back_idle", 128'(d_ret_valid), 128'(0));
        adv();
        m_ret_valid = 0; m_ret_last = 0;

        // Reset in the middle of a four-beat return.
        i_rd_req = 1; i_rd_type = 3'd4; i_rd_addr = 32'h0000_5000;
        step();
        i_rd_req = 0; m_rd_rdy = 1;
        step();
        m_rd_rdy = 0; m_ret_valid = 1; m_ret_last = 0; m_ret_data = 32'h7777_0000;
        step(); step();
        reset = 1;
        eval();
        chk("rst_i_ret",  128'(i_ret_valid), 128'(0));
        chk("rst_wr_rdy", 128'(d_wr_rdy),    128'(0));
        chk("rst_m_type", 128'(m_rd_type),   128'(0));
        adv();
        reset = 0;
        eval();
        chk("rst_no_stale_beat", 128'(i_ret_valid), 128'(0));
        adv();
        m_ret_valid = 0;
        i_rd_req = 1; i_rd_addr = 32'h0000_6000;
        eval();
        chk("rst_fresh_grant", 128'(i_rd_rdy), 128'(1));
        adv();
        i_rd_req = 0; m_rd_rdy = 1; m_ret_valid = 1; m_ret_last = 1;
        for (int c = 0; c < 4; c++) step();

        // Random traffic over a few lines so write hazards occur often.
        for (int c = 0; c < 2000; c++) begin
            reset       = ($urandom_range(0, 249) == 0);
            i_rd_req    = ($urandom_range(0, 2) != 0);
            i_rd_type   = ($urandom_range(0, 1) != 0) ? 3'd4 : 3'd2;
            i_rd_addr   = 32'h0000_2000 + 32'($urandom_range(0, 3)) * 32'd16 + 32'($urandom_range(0, 15));
            d_rd_req    = ($urandom_range(0, 2) != 0);
            d_rd_type   = 3'($urandom_range(0, 4));
            d_rd_addr   = 32'h0000_2000 + 32'($urandom_range(0, 3)) * 32'd16 + 32'($urandom_range(0, 15));
            d_wr_req    = ($urandom_range(0, 3) == 0);
            d_wr_addr   = 32'h0000_2000 + 32'($urandom_range(0, 3)) * 32'd16;
            d_wr_data   = {$urandom, $urandom, $urandom, $urandom};
            m_rd_rdy    = ($urandom_range(0, 1) != 0);
            m_ret_valid = ($urandom_range(0, 1) != 0);
            m_ret_last  = ($urandom_range(0, 2) == 0);
            m_ret_data  = $urandom;
            m_wr_rdy    = ($urandom_range(0, 1) != 0);
            m_wr_done   = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
